memory_port_arbiter: RTL and testbench

Sequences a single external memory port between the three pipeline requesters that need memory: instruction fetch, data read (read stage) and data write (write stage). Only one transaction is outstanding at a time. Each requester uses a req/ack handshake. The block sits between the pipeline stages and the Avalon-style memory master port. It includes a fetch-cancel path so that a PC change discards an in-flight instruction read.

---
 rtl/memory_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_memory_port_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/memory_port_arbiter.sv
// Arbitrates one Avalon-style memory master port between fetch, data read and data write.
// Optional fetch starvation guard: define MEMORY_PORT_ARBITER_STARVE_GUARD_EN.
module memory_port_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    input  logic          f_cancel,
    output logic          f_ack,
    output logic [DW-1:0] f_rdata,
    input  logic          r_req,
    input  logic [AW-1:0] r_addr,
    output logic          r_ack,
    output logic [DW-1:0] r_rdata,
    input  logic          w_req,
    input  logic [AW-1:0] w_addr,
    input  logic [DW-1:0] w_data,
    output logic          w_ack,
    output logic          m_read,
    output logic          m_write,
    output logic [AW-1:0] m_address,
    output logic [DW-1:0] m_writedata,
    input  logic          m_waitrequest,
    input  logic [DW-1:0] m_readdata,
    input  logic          m_readdatavalid
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DATA, ACK} state_t;
    typedef enum logic [1:0] {OWN_F, OWN_R, OWN_W} owner_t;

    state_t state, state_n;
    owner_t owner, owner_n;
    logic   discard;
    logic   grant_f, grant_r, grant_w, grant;
    logic   force_f;

    logic f_ok, accept, rd_done, cancel_hit, drop;
    assign f_ok       = f_req && !f_cancel;
    assign accept     = (state == ISSUE) && !m_waitrequest;
    assign rd_done    = (state == WAIT_DATA) && m_readdatavalid;
    // A cancel in the same cycle as the data return must also drop it.
    assign cancel_hit = f_cancel && (owner == OWN_F) && (state == ISSUE || state == WAIT_DATA);
    assign drop       = discard || cancel_hit;
    assign grant      = grant_f || grant_r || grant_w;

`ifdef MEMORY_PORT_ARBITER_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    logic [CW-1:0] starve_cnt;

    assign force_f = (starve_cnt == CW'(STARVE_LIMIT)) && f_ok;

    always_ff @(posedge clock) begin
        if (reset)
            starve_cnt <= '0;
        else if (!f_req || grant_f)
            starve_cnt <= '0;
        else if ((grant_r || grant_w) && starve_cnt != CW'(STARVE_LIMIT))
            starve_cnt <= starve_cnt + CW'(1);
    end
`else
    assign force_f = 1'b0;
`endif

    always_comb begin
        state_n = state;
        owner_n = owner;
        grant_f = 1'b0;
        grant_r = 1'b0;
        grant_w = 1'b0;
        case (state)
            IDLE: begin
                if (force_f)    grant_f = 1'b1;
                else if (w_req) grant_w = 1'b1;
                else if (r_req) grant_r = 1'b1;
                else if (f_ok)  grant_f = 1'b1;
                if (grant_w)      owner_n = OWN_W;
                else if (grant_r) owner_n = OWN_R;
                else if (grant_f) owner_n = OWN_F;
                if (grant_f || grant_r || grant_w) state_n = ISSUE;
            end
            ISSUE:     if (!m_waitrequest) state_n = (owner == OWN_W) ? ACK : WAIT_DATA;
            WAIT_DATA: if (m_readdatavalid) state_n = drop ? IDLE : ACK;
            ACK:       state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            owner <= OWN_F;
        end else begin
            state <= state_n;
            owner <= owner_n;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            m_read      <= 1'b0;
            m_write     <= 1'b0;
            m_address   <= '0;
            m_writedata <= '0;
            f_ack       <= 1'b0;
            r_ack       <= 1'b0;
            w_ack       <= 1'b0;
            f_rdata     <= '0;
            r_rdata     <= '0;
            discard     <= 1'b0;
        end else begin
            f_ack <= 1'b0;
            r_ack <= 1'b0;
            w_ack <= 1'b0;
            if (state_n == IDLE) discard <= 1'b0;
            else if (cancel_hit) discard <= 1'b1;
            if (grant) begin
                m_read    <= !grant_w;
                m_write   <= grant_w;
                m_address <= grant_w ? w_addr : (grant_r ? r_addr : f_addr);
                if (grant_w) m_writedata <= w_data;
            end
            if (accept) begin
                m_read  <= 1'b0;
                m_write <= 1'b0;
                if (owner == OWN_W) w_ack <= 1'b1;
            end
            if (rd_done && !drop) begin
                if (owner == OWN_R) begin
                    r_rdata <= m_readdata;
                    r_ack   <= 1'b1;
                end else if (owner == OWN_F) begin
                    f_rdata <= m_readdata;
                    f_ack   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Directed bench for memory_port_arbiter; starvation expectations follow
// MEMORY_PORT_ARBITER_STARVE_GUARD_EN.
module tb_memory_port_arbiter;

    localparam logic [31:0] OFF = 32'h1000_0000;

    logic        clock, reset;
    logic        f_req, f_cancel, f_ack, r_req, r_ack, w_req, w_ack;
    logic [31:0] f_addr, f_rdata, r_addr, r_rdata, w_addr, w_data;
    logic        m_read, m_write, m_waitrequest, m_readdatavalid;
    logic [31:0] m_address, m_writedata, m_readdata;

    int errors = 0;
    int checks = 0;
    int overlap, dbl, n_f, n_r, n_w;
    logic [31:0] order[$];

    memory_port_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(4)) dut (
        .clock(clock), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .f_cancel(f_cancel), .f_ack(f_ack), .f_rdata(f_rdata),
        .r_req(r_req), .r_addr(r_addr), .r_ack(r_ack), .r_rdata(r_rdata),
        .w_req(w_req), .w_addr(w_addr), .w_data(w_data), .w_ack(w_ack),
        .m_read(m_read), .m_write(m_write), .m_address(m_address), .m_writedata(m_writedata),
        .m_waitrequest(m_waitrequest), .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // Zero-wait memory responder plus requester behaviour: drop req on ack.
    task automatic serve(input int ncyc, input bit keep_r);
        logic        pend, prev_cmd, pf, pr, pw;
        logic [31:0] pend_addr;
        pend = 0; prev_cmd = 0; pf = 0; pr = 0; pw = 0; pend_addr = '0;
        for (int c = 0; c < ncyc; c++) begin
            tick();
            m_readdatavalid = pend;
            m_readdata      = pend_addr + OFF;
            pend      = m_read;
            pend_addr = m_address;
            if (m_read && m_write) overlap++;
            if ((m_read || m_write) && !prev_cmd) order.push_back(m_address);
            prev_cmd = m_read || m_write;
            if ((f_ack && pf) || (r_ack && pr) || (w_ack && pw)) dbl++;
            pf = f_ack; pr = r_ack; pw = w_ack;
            if (f_ack) begin n_f++; chk("serve_f_rdata", f_rdata, f_addr + OFF); f_req = 0; end
            if (r_ack) begin n_r++; chk("serve_r_rdata", r_rdata, r_addr + OFF); if (!keep_r) r_req = 0; end
            if (w_ack) begin n_w++; w_req = 0; end
        end
        m_readdatavalid = 0;
    endtask

    task automatic clr_stats();
        overlap = 0; dbl = 0; n_f = 0; n_r = 0; n_w = 0;
        order.delete();
    endtask

    initial begin
        reset = 1; f_req = 0; f_cancel = 0; r_req = 0; w_req = 0;
        f_addr = 0; r_addr = 0; w_addr = 0; w_data = 0;
        m_waitrequest = 0; m_readdata = 0; m_readdatavalid = 0;
        tick(); tick();
        chk("rst_m_read", {31'b0, m_read}, 0);
        chk("rst_m_write", {31'b0, m_write}, 0);
        chk("rst_m_address", m_address, 0);
        chk("rst_acks", {29'b0, f_ack, r_ack, w_ack}, 0);
        chk("rst_rdata", f_rdata | r_rdata, 0);
        reset = 0;
        tick();

        // Single fetch, zero waits
        f_req = 1; f_addr = 32'h100;
        tick();
        chk("fetch_c1_m_read", {31'b0, m_read}, 1);
        chk("fetch_c1_addr", m_address, 32'h100);
        chk("fetch_c1_f_ack", {31'b0, f_ack}, 0);
        tick();
        chk("fetch_c2_m_read", {31'b0, m_read}, 0);
        chk("fetch_c2_f_ack", {31'b0, f_ack}, 0);
        m_readdatavalid = 1; m_readdata = 32'hDEADBEEF;
        tick();
        m_readdatavalid = 0;
        chk("fetch_c3_f_ack", {31'b0, f_ack}, 1);
        chk("fetch_c3_f_rdata", f_rdata, 32'hDEADBEEF);
        tick();
        f_req = 0;
        chk("fetch_c4_f_ack", {31'b0, f_ack}, 0);
        chk("fetch_c4_hold", f_rdata, 32'hDEADBEEF);
        tick(); tick();

        // Write held by 3 waitrequest cycles
        w_req = 1; w_addr = 32'h20; w_data = 32'h55; m_waitrequest = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("wr_m_write", {31'b0, m_write}, 1);
            chk("wr_addr", m_address, 32'h20);
            chk("wr_data", m_writedata, 32'h55);
            chk("wr_no_ack", {31'b0, w_ack}, 0);
            if (i == 3) m_waitrequest = 0;
        end
        tick();
        chk("wr_ack", {31'b0, w_ack}, 1);
        chk("wr_cmd_off", {31'b0, m_write}, 0);
        w_req = 0;
        tick();
        chk("wr_ack_pulse", {31'b0, w_ack}, 0);

        // Three-way contention
        clr_stats();
        f_req = 1; f_addr = 32'h300; r_req = 1; r_addr = 32'h200;
        w_req = 1; w_addr = 32'h100; w_data = 32'hAA;
        serve(25, 0);
        chk("cont_n_grants", order.size(), 3);
        chk("cont_order0", order[0], 32'h100);
        chk("cont_order1", order[1], 32'h200);
        chk("cont_order2", order[2], 32'h300);
        chk("cont_acks", {n_f[7:0], n_r[7:0], n_w[7:0]}, 32'h010101);
        chk("cont_overlap", overlap, 0);
        chk("cont_dbl_ack", dbl, 0);

        // Fetch cancel while waiting for data
        f_req = 1; f_addr = 32'h400;
        tick();
        chk("cx_m_read", {31'b0, m_read}, 1);
        chk("cx_addr", m_address, 32'h400);
        tick();
        f_cancel = 1; f_req = 0;
        tick();
        f_cancel = 0; m_readdatavalid = 1; m_readdata = 32'h12345678;
        tick();
        m_readdatavalid = 0;
        chk("cx_no_f_ack", {31'b0, f_ack}, 0);
        chk("cx_f_rdata_held", f_rdata, OFF + 32'h300);
        r_req = 1; r_addr = 32'h500;
        tick();
        chk("cx_next_read", {31'b0, m_read}, 1);
        chk("cx_next_addr", m_address, 32'h500);
        tick();
        m_readdatavalid = 1; m_readdata = 32'hCAFE;
        tick();
        m_readdatavalid = 0;
        chk("cx_r_ack", {31'b0, r_ack}, 1);
        chk("cx_r_rdata", r_rdata, 32'hCAFE);
        chk("cx_f_ack_quiet", {31'b0, f_ack}, 0);
        r_req = 0;
        tick();
        chk("cx_r_ack_pulse", {31'b0, r_ack}, 0);

        // Reset during ISSUE, then a stray readdatavalid
        r_req = 1; r_addr = 32'h40; m_waitrequest = 1;
        tick();
        chk("rm_m_read", {31'b0, m_read}, 1);
        tick();
        reset = 1;
        tick();
        chk("rm_m_read_off", {31'b0, m_read}, 0);
        chk("rm_addr", m_address, 0);
        chk("rm_rdata", f_rdata | r_rdata, 0);
        reset = 0; r_req = 0; m_waitrequest = 0;
        m_readdatavalid = 1; m_readdata = 32'hBAD;
        tick();
        m_readdatavalid = 0;
        tick();
        chk("rm_stray_ack", {29'b0, f_ack, r_ack, w_ack}, 0);
        chk("rm_stray_rdata", r_rdata, 0);
        chk("rm_stray_cmd", {30'b0, m_read, m_write}, 0);

        // Starvation: r_req held continuously with f_req held
        clr_stats();
        f_req = 1; f_addr = 32'h700; r_req = 1; r_addr = 32'h600;
        serve(30, 1);
        r_req = 0; f_req = 0;
        serve(10, 0);
        chk("st_order0", order[0], 32'h600);
        chk("st_order3", order[3], 32'h600);
`ifdef MEMORY_PORT_ARBITER_STARVE_GUARD_EN
        chk("st_order4", order[4], 32'h700);
        chk("st_n_f", n_f, 1);
`else
        chk("st_order4", order[4], 32'h600);
        chk("st_n_f", n_f, 0);
`endif
        chk("st_overlap", overlap, 0);
        chk("st_idle", {30'b0, m_read, m_write}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
